// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    // Access FSM: IDLE samples the M stage, REQ presents the request,
    // WAIT collects read data, DONE releases the pipeline for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // RV64I load/store funct3 encodings (stores use only the first four).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Width of a counter that must be able to hold the value TIMEOUT.
    function automatic int timeoutCntWidth(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, load
// shift/extension, and misaligned/illegal access detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [2:0]  addrOff,
    input  logic [63:0] storeData,
    output logic [63:0] storeBeat,
    output logic [7:0]  storeStrb,
    output logic        accessFault,
    input  logic [2:0]  loadFunct3,
    input  logic [2:0]  loadOff,
    input  logic [63:0] respData,
    output logic [63:0] loadResult
);

    logic        misaligned;
    logic        illegal;
    logic [63:0] shifted;

    // Store formatting: replicate the operand into every lane and enable
    // only the lanes covered by the access.
    always_comb begin
        storeBeat = storeData;
        storeStrb = 8'hFF;
        unique case (funct3[1:0])
            2'b00: begin
                storeBeat = {8{storeData[7:0]}};
                storeStrb = 8'h01 << addrOff;
            end
            2'b01: begin
                storeBeat = {4{storeData[15:0]}};
                storeStrb = 8'h03 << addrOff;
            end
            2'b10: begin
                storeBeat = {2{storeData[31:0]}};
                storeStrb = 8'h0F << addrOff;
            end
            default: begin
                storeBeat = storeData;
                storeStrb = 8'hFF;
            end
        endcase
    end

    // Fault detection: natural alignment per size, plus funct3 codes
    // that have no meaning for the requested operation.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        unique case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addrOff[0];
            2'b10:   misaligned = (addrOff[1:0] != 2'b00);
            default: misaligned = (addrOff != 3'b000);
        endcase
        if (isLoad) begin
            illegal = (funct3 == 3'b111);
        end else if (isStore) begin
            illegal = funct3[2];
        end
        accessFault = (isLoad || isStore) && (misaligned || illegal);
    end

    // Load extraction: bring the addressed bytes down to bit 0, then
    // sign- or zero-extend according to the latched funct3.
    always_comb begin
        shifted    = respData >> {loadOff, 3'b000};
        loadResult = '0;
        unique case (loadFunct3)
            F3_B:    loadResult = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    loadResult = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    loadResult = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    loadResult = shifted;
            F3_BU:   loadResult = {56'b0, shifted[7:0]};
            F3_HU:   loadResult = {48'b0, shifted[15:0]};
            F3_WU:   loadResult = {32'b0, shifted[31:0]};
            default: loadResult = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store initiator: turns M-stage loads/stores into
// valid/ready requests, stalls the pipeline until completion, and reports
// misaligned accesses and bus timeouts.
//
// Handshake: mem_req_valid is asserted only in REQ and, together with
// we/addr/wdata/wstrb, stays stable until the cycle where mem_req_ready is
// also high (the transfer edge); it is withdrawn without a transfer only on
// timeout or reset. mem_resp_valid is a single-beat response with no
// back-pressure and is consumed only while in WAIT.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  Funct3_M,
    input  logic [63:0] ALUResult_M,
    input  logic [63:0] WriteData_M,
    output logic [63:0] ReadData_M,
    output logic        Stall_M,
    output logic        MisalignFault_M,
    output logic        BusFault_M,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output lsu_state_t  lsuState
);

    localparam int CW = timeoutCntWidth(int'(TIMEOUT));
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state;
    lsu_state_t    stateNext;
    logic [CW-1:0] cnt;
    logic [2:0]    reqFunct3;
    logic [2:0]    reqOff;
    logic          access;
    logic          accessFault;
    logic          startAccess;
    logic          loadDone;
    logic          timeoutHit;
    logic          cntLast;
    logic [63:0]   storeBeat;
    logic [7:0]    storeStrb;
    logic [63:0]   loadResult;

    assign access        = MemRead_M || MemWrite_M;
    assign cntLast       = (cnt >= CNT_LAST);
    assign mem_req_valid = (state == REQ);
    assign lsuState      = state;

    lsu_align uAlign (
        .isLoad      (MemRead_M),
        .isStore     (MemWrite_M),
        .funct3      (Funct3_M),
        .addrOff     (ALUResult_M[2:0]),
        .storeData   (WriteData_M),
        .storeBeat   (storeBeat),
        .storeStrb   (storeStrb),
        .accessFault (accessFault),
        .loadFunct3  (reqFunct3),
        .loadOff     (reqOff),
        .respData    (mem_resp_rdata),
        .loadResult  (loadResult)
    );

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and pipeline control; completion wins over a timeout
    // that expires in the same cycle.
    always_comb begin
        stateNext       = state;
        Stall_M         = 1'b0;
        MisalignFault_M = 1'b0;
        startAccess     = 1'b0;
        loadDone        = 1'b0;
        timeoutHit      = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (accessFault) begin
                        MisalignFault_M = 1'b1;
                    end else begin
                        Stall_M     = 1'b1;
                        startAccess = 1'b1;
                        stateNext   = REQ;
                    end
                end
            end
            REQ: begin
                Stall_M = 1'b1;
                if (mem_req_ready) begin
                    stateNext = mem_req_we ? DONE : WAIT;
                end else if (cntLast) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            WAIT: begin
                Stall_M = 1'b1;
                if (mem_resp_valid) begin
                    loadDone  = 1'b1;
                    stateNext = DONE;
                end else if (cntLast) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request registers: captured once in IDLE and held through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            reqFunct3     <= '0;
            reqOff        <= '0;
        end else if (startAccess) begin
            mem_req_we    <= MemWrite_M;
            mem_req_addr  <= {ALUResult_M[63:3], 3'b000};
            mem_req_wdata <= MemWrite_M ? storeBeat : '0;
            mem_req_wstrb <= MemWrite_M ? storeStrb : 8'h00;
            reqFunct3     <= Funct3_M;
            reqOff        <= ALUResult_M[2:0];
        end
    end

    // Timeout counter: cleared on entry to REQ, counts REQ/WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (startAccess) begin
            cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Result registers: load data holds until the next load completes;
    // a timeout clears it and raises a one-cycle bus fault in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData_M <= '0;
            BusFault_M <= 1'b0;
        end else begin
            BusFault_M <= timeoutHit;
            if (loadDone) begin
                ReadData_M <= loadResult;
            end else if (timeoutHit) begin
                ReadData_M <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases followed by random
// loads/stores against a byte-level reference model and a simple responder.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [2:0]  Funct3_M;
    logic [63:0] ALUResult_M;
    logic [63:0] WriteData_M;
    logic [63:0] ReadData_M;
    logic        Stall_M;
    logic        MisalignFault_M;
    logic        BusFault_M;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    lsu_state_t  lsuState;

    int          n_checks;
    int          n_pass;
    logic [63:0] exp_read;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MemRead_M       (MemRead_M),
        .MemWrite_M      (MemWrite_M),
        .Funct3_M        (Funct3_M),
        .ALUResult_M     (ALUResult_M),
        .WriteData_M     (WriteData_M),
        .ReadData_M      (ReadData_M),
        .Stall_M         (Stall_M),
        .MisalignFault_M (MisalignFault_M),
        .BusFault_M      (BusFault_M),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wstrb   (mem_req_wstrb),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .lsuState        (lsuState)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference model: byte-level view of the access rules.
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit exp_fault(input bit is_load, input logic [2:0] f3, input logic [63:0] a);
        int sz;
        sz = size_bytes(f3);
        if (is_load && f3 == 3'b111) return 1'b1;
        if (!is_load && f3 >= 3'b100) return 1'b1;
        return (int'(a[2:0]) % sz) != 0;
    endfunction

    function automatic logic [63:0] exp_beat(input logic [2:0] f3, input logic [63:0] wd);
        logic [63:0] r;
        int sz;
        sz = size_bytes(f3);
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = wd[(i % sz)*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] exp_strb(input logic [2:0] f3, input int off);
        logic [7:0] r;
        int sz;
        sz = size_bytes(f3);
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (i >= off) && (i < off + sz);
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
        logic [63:0] r;
        int sz;
        sz = size_bytes(f3);
        r = '0;
        for (int i = 0; i < sz; i++) r[i*8 +: 8] = rd[(off + i)*8 +: 8];
        if (f3 < 3'b100 && sz < 8 && r[sz*8 - 1]) begin
            for (int i = sz; i < 8; i++) r[i*8 +: 8] = 8'hFF;
        end
        return r;
    endfunction

    // Driver + responder for one access, checked every cycle.
    task automatic do_access(input bit is_load, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input int rdy_dly, input int rsp_dly,
                             input logic [63:0] rdata, input bit silent);
        bit          fault;
        bit          completes;
        int          exp_k;
        int          req_n;
        int          wait_n;
        int          done_k;
        logic [63:0] e_addr;
        logic [63:0] e_beat;
        logic [7:0]  e_strb;

        fault = exp_fault(is_load, f3, addr);
        @(negedge clk);
        MemRead_M   = is_load;
        MemWrite_M  = !is_load;
        Funct3_M    = f3;
        ALUResult_M = addr;
        WriteData_M = wd;
        #1;
        check("idle_state", 64'(lsuState), 64'(IDLE));
        check("read_hold", ReadData_M, exp_read);
        check("misalign", 64'(MisalignFault_M), 64'(fault));
        check("idle_stall", 64'(Stall_M), 64'(!fault));
        if (fault) begin
            repeat (2) begin
                @(negedge clk);
                #1;
                check("fault_no_valid", 64'(mem_req_valid), 64'd0);
                check("fault_stay_idle", 64'(lsuState), 64'(IDLE));
            end
            MemRead_M  = 1'b0;
            MemWrite_M = 1'b0;
            return;
        end

        e_addr    = {addr[63:3], 3'b000};
        e_beat    = exp_beat(f3, wd);
        e_strb    = is_load ? 8'h00 : exp_strb(f3, int'(addr[2:0]));
        completes = is_load ? (!silent && (rdy_dly + rsp_dly + 2 <= TIMEOUT))
                            : (rdy_dly + 1 <= TIMEOUT);
        exp_k     = !completes ? TIMEOUT : (is_load ? rdy_dly + rsp_dly + 2 : rdy_dly + 1);
        req_n     = 0;
        wait_n    = 0;
        done_k    = -1;

        for (int k = 0; k < TIMEOUT + 4 && done_k < 0; k++) begin
            @(negedge clk);
            #1;
            if (lsuState == DONE) begin
                done_k         = k;
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                MemRead_M      = 1'b0;
                MemWrite_M     = 1'b0;
                if (!completes) exp_read = '0;
                else if (is_load) exp_read = exp_load(f3, int'(addr[2:0]), rdata);
                check("latency", 64'(k), 64'(exp_k));
                check("done_stall", 64'(Stall_M), 64'd0);
                check("done_valid", 64'(mem_req_valid), 64'd0);
                check("bus_fault", 64'(BusFault_M), 64'(!completes));
                check("read_data", ReadData_M, exp_read);
            end else if (mem_req_valid) begin
                check("req_state", 64'(lsuState), 64'(REQ));
                check("req_stall", 64'(Stall_M), 64'd1);
                check("req_we", 64'(mem_req_we), 64'(!is_load));
                check("req_addr", mem_req_addr, e_addr);
                check("req_wstrb", 64'(mem_req_wstrb), 64'(e_strb));
                if (!is_load) check("req_wdata", mem_req_wdata, e_beat);
                req_n++;
                mem_req_ready  = (req_n > rdy_dly);
                // Spurious response outside WAIT must be ignored.
                mem_resp_valid = ($urandom_range(0, 3) == 0);
                mem_resp_rdata = {$urandom, $urandom};
            end else begin
                check("wait_state", 64'(lsuState), 64'(WAIT));
                check("wait_stall", 64'(Stall_M), 64'd1);
                check("wait_bus_fault", 64'(BusFault_M), 64'd0);
                mem_req_ready  = 1'b0;
                wait_n++;
                mem_resp_valid = !silent && (wait_n > rsp_dly);
                mem_resp_rdata = mem_resp_valid ? rdata : {$urandom, $urandom};
            end
        end
        if (done_k < 0) begin
            check("done_reached", 64'd0, 64'd1);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            MemRead_M      = 1'b0;
            MemWrite_M     = 1'b0;
        end
    endtask

    initial begin
        bit          is_load;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          rdy;
        int          rsp;

        n_checks       = 0;
        n_pass         = 0;
        exp_read       = '0;
        rst_n          = 1'b0;
        MemRead_M      = 1'b0;
        MemWrite_M     = 1'b0;
        Funct3_M       = '0;
        ALUResult_M    = '0;
        WriteData_M    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 64'(lsuState), 64'(IDLE));
        check("rst_valid", 64'(mem_req_valid), 64'd0);
        check("rst_we", 64'(mem_req_we), 64'd0);
        check("rst_addr", mem_req_addr, 64'd0);
        check("rst_wdata", mem_req_wdata, 64'd0);
        check("rst_wstrb", 64'(mem_req_wstrb), 64'd0);
        check("rst_read", ReadData_M, 64'd0);
        check("rst_bus_fault", 64'(BusFault_M), 64'd0);
        rst_n = 1'b1;

        // Directed cases
        do_access(1'b0, F3_D, 64'h10, 64'hABCDE1234567890F, 0, 0, 64'd0, 1'b0);
        do_access(1'b0, F3_B, 64'h13, 64'h11223344556677A5, 3, 0, 64'd0, 1'b0);
        do_access(1'b1, F3_B, 64'h15, 64'd0, 0, 0, 64'h0000800000000000, 1'b0);
        check("lb_value", exp_read, 64'hFFFFFFFFFFFFFF80);
        do_access(1'b1, F3_BU, 64'h15, 64'd0, 1, 2, 64'h0000800000000000, 1'b0);
        check("lbu_value", exp_read, 64'h80);
        do_access(1'b1, F3_WU, 64'h14, 64'd0, 0, 1, 64'h8765432100000000, 1'b0);
        check("lwu_value", exp_read, 64'h87654321);
        do_access(1'b1, F3_W, 64'h12, 64'd0, 0, 0, 64'd0, 1'b0);
        do_access(1'b1, 3'b111, 64'h18, 64'd0, 0, 0, 64'd0, 1'b0);
        do_access(1'b0, F3_BU, 64'h18, 64'h5, 0, 0, 64'd0, 1'b0);
        do_access(1'b1, F3_D, 64'h20, 64'd0, 0, 0, 64'd0, 1'b1);
        do_access(1'b0, F3_H, 64'h26, 64'h1234BEEF, 9, 0, 64'd0, 1'b0);
        do_access(1'b1, F3_HU, 64'h2A, 64'd0, 0, 0, 64'h1234567890ABCDEF, 1'b0);

        // Reset during WAIT: async return to IDLE, late response ignored.
        @(negedge clk);
        MemRead_M   = 1'b1;
        Funct3_M    = F3_D;
        ALUResult_M = 64'h40;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        MemRead_M     = 1'b0;
        @(negedge clk);
        check("pre_rst_wait", 64'(lsuState), 64'(WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 64'(lsuState), 64'(IDLE));
        check("async_rst_valid", 64'(mem_req_valid), 64'd0);
        exp_read       = '0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("late_resp_state", 64'(lsuState), 64'(IDLE));
        check("late_resp_read", ReadData_M, 64'd0);

        // Random accesses
        for (int n = 0; n < 80; n++) begin
            is_load = $urandom_range(0, 1) == 1;
            f3      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3[2] = is_load ? f3[2] : 1'b0;
            if (is_load && f3 == 3'b111 && $urandom_range(0, 1) == 1) f3 = F3_D;
            addr    = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) addr[2:0] = addr[2:0] & ~3'(size_bytes(f3) - 1);
            rdy     = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
            rsp     = $urandom_range(0, 4);
            do_access(is_load, f3, addr, {$urandom, $urandom}, rdy, rsp,
                      {$urandom, $urandom}, $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        check("final_idle", 64'(lsuState), 64'(IDLE));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
